// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFETCH_MISALIGN_EN (see ifetch_unit.sv).
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  // One buffer slot: the PC it was fetched from, the returned word, whether
  // the word has arrived, and whether it was synthesised for a misaligned PC.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
    logic            misalign;
  } fetch_entry_t;

  // Width of counters able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response channel plus the decode-side
// valid/ready channel of the fetch unit.
// Optional feature macro: IFETCH_MISALIGN_EN adds inst_misalign.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
`ifdef IFETCH_MISALIGN_EN
  logic            inst_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
`endif

endinterface

// File: rtl/ifetch_buf.sv
// DEPTH-entry circular fetch buffer: allocate at tail, fill the oldest
// unfilled entry, pop the head, clear everything. Entries between head and
// head+count are live; slot contents outside that window are don't-care,
// so the storage array itself carries no reset.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        alloc,
  input  fetch_entry_t                alloc_entry,
  input  logic                        fill,
  input  logic [XLEN-1:0]             fill_data,
  input  logic                        pop,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic [cnt_width(DEPTH)-1:0] pending,
  output fetch_entry_t                head_entry
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] unfilled;
  logic [PW-1:0]    fill_idx;
  logic             fill_hit;

  // Per-slot liveness: a slot is live when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] offset;
    assign offset       = PW'(gi) - head_reg;
    assign live[gi]     = {1'b0, offset} < count_reg;
    assign unfilled[gi] = live[gi] & ~mem[gi].filled;
  end

  // Locate the oldest live entry still waiting for its memory response.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fill_idx = head_reg;
    fill_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg + PW'(i);
      if (!fill_hit && unfilled[idx]) begin
        fill_hit = 1'b1;
        fill_idx = idx;
      end
    end
  end

  // Count the outstanding memory fetches held in the buffer.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending + CW'(unfilled[i]);
    end
  end

  // Pointer and occupancy bookkeeping; clear returns to the empty state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc) tail_reg <= tail_reg + PW'(1);
      if (pop)   head_reg <= head_reg + PW'(1);
      count_reg <= count_reg + CW'(alloc) - CW'(pop);
    end
  end

  // Slot storage: allocation writes a whole entry, fill lands data on a pending one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && tail_reg == PW'(i)) begin
        mem[i] <= alloc_entry;
      end else if (fill && fill_hit && fill_idx == PW'(i)) begin
        mem[i].data   <= fill_data;
        mem[i].filled <= 1'b1;
      end
    end
  end

  assign count      = count_reg;
  assign head_entry = mem[head_reg];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues in-order imem reads for pc_in under a
// credit limit, buffers returned words tagged with their PC and hands them
// to decode over valid/ready. A flush discards buffered entries and counts
// in-flight requests so their late responses are dropped.
// Optional feature macro: IFETCH_MISALIGN_EN -- misaligned PCs are not sent
// to memory; a NOP entry flagged inst_misalign is queued instead.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_take,
  input  logic            flush,
  ifetch_if.master        bus
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] pending;
  logic [CW-1:0] discard_reg;
  logic [CW-1:0] discard_next;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          issue_ok;
  logic          fill;
  logic          pop;
  logic          inst_valid;
  fetch_entry_t  head_entry;
  fetch_entry_t  alloc_entry;
  logic [XLEN-1:0] data_hold_reg;
  logic [XLEN-1:0] pc_hold_reg;

  // Requests already discarded still occupy credit until their data returns.
  assign credit_sum = {1'b0, count} + {1'b0, discard_reg};
  assign credit_ok  = credit_sum < (CW + 1)'(DEPTH);
  assign issue_ok   = credit_ok & ~flush & ~rst;

`ifdef IFETCH_MISALIGN_EN
  logic misalign;
  assign misalign           = pc_in[1:0] != 2'b00;
  assign bus.imem_req_valid = issue_ok & ~misalign;
  assign bus.imem_req_addr  = pc_in;
  assign pc_take            = misalign ? issue_ok : (bus.imem_req_valid & bus.imem_req_ready);

  // Misaligned fetches enter the buffer already complete with a NOP.
  always_comb begin
    alloc_entry          = '0;
    alloc_entry.pc       = pc_in;
    alloc_entry.data     = misalign ? NOP_INST : '0;
    alloc_entry.filled   = misalign;
    alloc_entry.misalign = misalign;
  end
`else
  assign bus.imem_req_valid = issue_ok;
  assign bus.imem_req_addr  = {pc_in[XLEN-1:2], 2'b00};
  assign pc_take            = bus.imem_req_valid & bus.imem_req_ready;

  // Every allocated entry waits for its memory response.
  always_comb begin
    alloc_entry          = '0;
    alloc_entry.pc       = pc_in;
    alloc_entry.data     = '0;
    alloc_entry.filled   = 1'b0;
    alloc_entry.misalign = 1'b0;
  end
`endif

  // Responses owed to flushed requests are consumed by the discard counter.
  assign fill = bus.imem_rsp_valid & (discard_reg == '0) & ~flush;

  assign inst_valid = (count != '0) & head_entry.filled & ~rst;
  assign pop        = inst_valid & bus.inst_ready & ~flush;

  ifetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear       (flush),
    .alloc       (pc_take),
    .alloc_entry (alloc_entry),
    .fill        (fill),
    .fill_data   (bus.imem_rsp_data),
    .pop         (pop),
    .count       (count),
    .pending     (pending),
    .head_entry  (head_entry)
  );

  // Discard bookkeeping: a flush adds every unreturned request, less one
  // if a response is consumed in the same cycle.
  always_comb begin
    discard_next = discard_reg;
    if (flush) begin
      discard_next = discard_reg + pending
                   - CW'(bus.imem_rsp_valid && (discard_reg != '0 || pending != '0));
    end else if (bus.imem_rsp_valid && discard_reg != '0) begin
      discard_next = discard_reg - CW'(1);
    end
  end

  // Discard counter register.
  always_ff @(posedge clk) begin
    if (rst) discard_reg <= '0;
    else     discard_reg <= discard_next;
  end

  // Remember the last word shown to decode so an empty buffer holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_hold_reg <= '0;
      pc_hold_reg   <= '0;
    end else if (inst_valid) begin
      data_hold_reg <= head_entry.data;
      pc_hold_reg   <= head_entry.pc;
    end
  end

  assign bus.inst_valid = inst_valid;
  assign bus.inst_data  = rst ? '0 : (inst_valid ? head_entry.data : data_hold_reg);
  assign bus.inst_pc    = rst ? '0 : (inst_valid ? head_entry.pc   : pc_hold_reg);

`ifdef IFETCH_MISALIGN_EN
  assign bus.inst_misalign = inst_valid & head_entry.misalign;
`else
  // Without the feature no entry can ever carry the misalign flag.
  a_no_misalign: assert property (@(posedge clk) disable iff (rst)
    !(inst_valid && head_entry.misalign));
`endif

  // A response with nothing pending and nothing to discard is a protocol error.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && discard_reg == '0 && pending == '0));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit (DEPTH=2). Memory responses are driven
// by hand; every expected value below is computed from the stimulus.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] pc_in;
  logic        pc_take;
  int          checks;
  int          errors;

  ifetch_if bus ();

  ifetch_unit #(
    .DEPTH (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_in   (pc_in),
    .pc_take (pc_take),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present pc for one cycle with ready high and expect it to be taken.
  task automatic issue(input logic [31:0] pc, input string tag);
    pc_in = pc;
    bus.imem_req_ready = 1'b1;
    #1;
    check(tag, pc_take, 1);
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
  endtask

  task automatic rsp(input logic [31:0] d);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
  endtask

  task automatic pop();
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    pc_in = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;

    // Reset: outputs quiet even with ready high.
    tick();
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_pc_take", pc_take, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_inst_data", bus.inst_data, 0);
    check("rst_inst_pc", bus.inst_pc, 0);

    // Basic fetch, response one cycle after the request.
    rst = 1'b0;
    #1;
    check("t1_req_valid", bus.imem_req_valid, 1);
    check("t1_req_addr", bus.imem_req_addr, 32'h0);
    check("t1_pc_take", pc_take, 1);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = dat(32'h0);
    #1;
    check("t1_no_bypass", bus.inst_valid, 0);
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    check("t1_inst_valid", bus.inst_valid, 1);
    check("t1_inst_pc", bus.inst_pc, 32'h0);
    check("t1_inst_data", bus.inst_data, dat(32'h0));
    pop();
    check("t1_empty", bus.inst_valid, 0);
    check("t1_hold_data", bus.inst_data, dat(32'h0));

    // Full buffer: two fetches issue, then the unit holds until a pop.
    bus.imem_req_ready = 1'b1;
    pc_in = 32'h0;
    #1;
    check("t2_take0", pc_take, 1);
    tick();
    pc_in = 32'h4;
    #1;
    check("t2_take4", pc_take, 1);
    tick();
    pc_in = 32'h8;
    #1;
    check("t2_full_req_valid", bus.imem_req_valid, 0);
    check("t2_full_take", pc_take, 0);
    tick();
    check("t2_full_take_hold", pc_take, 0);
    rsp(dat(32'h0));
    rsp(dat(32'h4));
    check("t2_head_pc", bus.inst_pc, 32'h0);
    check("t2_head_data", bus.inst_data, dat(32'h0));
    check("t2_full_after_rsp", pc_take, 0);
    pop();
    check("t2_take8", pc_take, 1);
    check("t2_addr8", bus.imem_req_addr, 32'h8);
    check("t2_head_pc4", bus.inst_pc, 32'h4);
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
    rsp(dat(32'h8));
    check("t2_head_still4", bus.inst_pc, 32'h4);
    pop();
    check("t2_head_pc8", bus.inst_pc, 32'h8);
    check("t2_head_data8", bus.inst_data, dat(32'h8));
    pop();
    check("t2_drained", bus.inst_valid, 0);

    // Flush with two fetches outstanding; both responses dropped.
    issue(32'h10, "t3_take10");
    issue(32'h14, "t3_take14");
    flush = 1'b1;
    bus.imem_req_ready = 1'b1;
    #1;
    check("t3_flush_take", pc_take, 0);
    tick();
    flush = 1'b0;
    bus.imem_req_ready = 1'b0;
    #1;
    check("t3_credit_blocked", bus.imem_req_valid, 0);
    check("t3_inst_valid0", bus.inst_valid, 0);
    rsp(dat(32'h10));
    check("t3_drop10", bus.inst_valid, 0);
    check("t3_credit_back1", bus.imem_req_valid, 1);
    rsp(dat(32'h14));
    check("t3_drop14", bus.inst_valid, 0);
    issue(32'h100, "t3_take100");
    rsp(dat(32'h100));
    check("t3_valid100", bus.inst_valid, 1);
    check("t3_pc100", bus.inst_pc, 32'h100);
    check("t3_data100", bus.inst_data, dat(32'h100));
    pop();

    // Flush coinciding with a response, another fetch still in flight.
    issue(32'h30, "t4_take30");
    issue(32'h34, "t4_take34");
    flush = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = dat(32'h30);
    tick();
    flush = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    check("t4_discard1_credit", bus.imem_req_valid, 1);
    check("t4_inst_valid0", bus.inst_valid, 0);
    issue(32'h200, "t4_take200");
    check("t4_credit_full", bus.imem_req_valid, 0);
    rsp(dat(32'h34));
    check("t4_drop34", bus.inst_valid, 0);
    rsp(dat(32'h200));
    check("t4_valid200", bus.inst_valid, 1);
    check("t4_pc200", bus.inst_pc, 32'h200);
    check("t4_data200", bus.inst_data, dat(32'h200));
    pop();

    // Memory not ready for three cycles.
    pc_in = 32'h20;
    bus.imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t5_req_valid", bus.imem_req_valid, 1);
      check("t5_stall_take", pc_take, 0);
      tick();
    end
    bus.imem_req_ready = 1'b1;
    #1;
    check("t5_take20", pc_take, 1);
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
    check("t5_take_after", pc_take, 0);
    rsp(dat(32'h20));
    check("t5_pc20", bus.inst_pc, 32'h20);
    // Issue and pop on the same edge.
    bus.inst_ready = 1'b1;
    pc_in = 32'h24;
    bus.imem_req_ready = 1'b1;
    #1;
    check("t5_take24_pop", pc_take, 1);
    tick();
    bus.inst_ready = 1'b0;
    bus.imem_req_ready = 1'b0;
    #1;
    check("t5_single_entry", bus.inst_valid, 0);
    rsp(dat(32'h24));
    check("t5_pc24", bus.inst_pc, 32'h24);
    check("t5_data24", bus.inst_data, dat(32'h24));
    pop();
    check("t5_empty", bus.inst_valid, 0);
    check("t5_credit_free", bus.imem_req_valid, 1);
    check("t5_hold_pc", bus.inst_pc, 32'h24);

`ifdef IFETCH_MISALIGN_EN
    // Misaligned PC queued behind an older aligned fetch.
    issue(32'h40, "t6_take40");
    pc_in = 32'h22;
    bus.imem_req_ready = 1'b1;
    #1;
    check("t6_no_req", bus.imem_req_valid, 0);
    check("t6_take22", pc_take, 1);
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
    check("t6_wait_older", bus.inst_valid, 0);
    rsp(dat(32'h40));
    check("t6_pc40", bus.inst_pc, 32'h40);
    check("t6_mis40", bus.inst_misalign, 0);
    pop();
    check("t6_valid22", bus.inst_valid, 1);
    check("t6_pc22", bus.inst_pc, 32'h22);
    check("t6_nop", bus.inst_data, 32'h00000013);
    check("t6_mis22", bus.inst_misalign, 1);
    pop();
    check("t6_empty", bus.inst_valid, 0);
`else
    // Low address bits are dropped on the request.
    pc_in = 32'h22;
    #1;
    check("t6_addr_align", bus.imem_req_addr, 32'h20);
`endif

    // Reset in the middle of an outstanding fetch.
    issue(32'h50, "t7_take50");
    rst = 1'b1;
    #1;
    check("t7_rst_req_valid", bus.imem_req_valid, 0);
    check("t7_rst_inst_valid", bus.inst_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t7_post_inst_valid", bus.inst_valid, 0);
    check("t7_post_credit", bus.imem_req_valid, 1);
    check("t7_post_data", bus.inst_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
